// File: rtl/pipe_addsub_radix4.sv
// Pipelined W-bit adder/subtractor, one radix-4 digit per stage.
// Global-stall valid/ready pipeline; flags travel with the data.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   operand transaction valid
//   in_ready   transaction accepted this cycle
//   in_a       operand A
//   in_b       operand B
//   in_sub     0: A+B, 1: A-B
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_sum    A+/-B modulo 2^W
//   out_cout   carry out of MSB digit (sub: 1 = no borrow)
//   out_ovf    signed two's-complement overflow
module pipe_addsub_radix4 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_sum,
   output logic         out_cout,
   output logic         out_ovf
);

   localparam int S = W / 2;

   // Weighted 5-input digit sum: bits 4,3 weigh 2, bits 2..0 weigh 1.
   // Result [1:0] is the digit, [2] the carry; max value 7 -> 3/carry.
   function automatic logic [2:0] f_dsum(input logic [4:0] idx);
      f_dsum = {1'b0, idx[4], 1'b0}
             + {1'b0, idx[3], 1'b0}
             + {2'b0, idx[2]}
             + {2'b0, idx[1]}
             + {2'b0, idx[0]};
   endfunction

   logic         r_v   [S];
   logic         r_c   [S];
   logic [W-1:0] r_sum [S];
   logic [W-1:0] r_a   [S];
   logic [W-1:0] r_b   [S];

   logic         w_adv;
   logic [W-1:0] w_b;
   logic [2:0]   w_d   [S];
   logic [W-1:0] w_s   [S];

   // Whole pipe moves together; it only stalls when the tail
   // holds a result the consumer has not taken.
   assign w_adv    = ~r_v[S-1] | out_ready;
   assign in_ready = w_adv;

   // Subtraction as A + ~B + 1, the +1 entering as digit-0 carry.
   assign w_b = in_sub ? ~in_b : in_b;

   always_comb begin
      for (int k = 0; k < S; k++) begin
         w_d[k] = '0;
         w_s[k] = '0;
      end
      w_d[0] = f_dsum({in_a[1], w_b[1],
                       in_a[0], w_b[0], in_sub});
      w_s[0][1:0] = w_d[0][1:0];
      for (int k = 1; k < S; k++) begin
         w_d[k] = f_dsum({r_a[k-1][2*k+1],
                          r_b[k-1][2*k+1],
                          r_a[k-1][2*k],
                          r_b[k-1][2*k],
                          r_c[k-1]});
         w_s[k] = r_sum[k-1];
         w_s[k][2*k +: 2] = w_d[k][1:0];
      end
   end

   // Data registers load only with a valid token so bubbles leave
   // the last result in place.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < S; k++) begin
            r_v[k]   <= 1'b0;
            r_c[k]   <= 1'b0;
            r_sum[k] <= '0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
         end
      end else if (w_adv) begin
         r_v[0] <= in_valid;
         if (in_valid) begin
            r_sum[0] <= w_s[0];
            r_c[0]   <= w_d[0][2];
            r_a[0]   <= in_a;
            r_b[0]   <= w_b;
         end
         for (int k = 1; k < S; k++) begin
            r_v[k] <= r_v[k-1];
            if (r_v[k-1]) begin
               r_sum[k] <= w_s[k];
               r_c[k]   <= w_d[k][2];
               r_a[k]   <= r_a[k-1];
               r_b[k]   <= r_b[k-1];
            end
         end
      end
   end

   assign out_valid = r_v[S-1];
   assign out_sum   = r_sum[S-1];
   assign out_cout  = r_c[S-1];
   assign out_ovf   = (r_a[S-1][W-1] == r_b[S-1][W-1])
                    & (r_sum[S-1][W-1] != r_a[S-1][W-1]);

endmodule

// File: tb/tb_pipe_addsub_radix4.sv
// Bench for pipe_addsub_radix4 at W=8 and W=16.
// Queue scoreboard fed at transfer, drained at output handshake.
module tb_pipe_addsub_radix4;

   logic        clk;
   logic        rst;
   logic        iv   [2];
   logic        ir   [2];
   logic        sb   [2];
   logic        ov   [2];
   logic        ordy [2];
   logic        co   [2];
   logic        of   [2];
   logic [15:0] ia   [2];
   logic [15:0] ib   [2];
   logic [15:0] os   [2];

   logic [7:0]  ia8, ib8, os8;
   logic [15:0] os16;

   logic [17:0] q    [2][$];
   int          npush[2];
   int          nout [2];
   logic        hld  [2];
   logic [17:0] hv   [2];

   int n_tot = 0;
   int n_bad = 0;

   assign ia8   = ia[0][7:0];
   assign ib8   = ib[0][7:0];
   assign os[0] = {8'h00, os8};
   assign os[1] = os16;

   pipe_addsub_radix4 #(.W(8)) u_dut8 (
      .clk       (clk),
      .reset     (rst),
      .in_valid  (iv[0]),
      .in_ready  (ir[0]),
      .in_a      (ia8),
      .in_b      (ib8),
      .in_sub    (sb[0]),
      .out_valid (ov[0]),
      .out_ready (ordy[0]),
      .out_sum   (os8),
      .out_cout  (co[0]),
      .out_ovf   (of[0])
   );

   pipe_addsub_radix4 #(.W(16)) u_dut16 (
      .clk       (clk),
      .reset     (rst),
      .in_valid  (iv[1]),
      .in_ready  (ir[1]),
      .in_a      (ia[1]),
      .in_b      (ib[1]),
      .in_sub    (sb[1]),
      .out_valid (ov[1]),
      .out_ready (ordy[1]),
      .out_sum   (os16),
      .out_cout  (co[1]),
      .out_ovf   (of[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference built from integer arithmetic, not digit logic.
   function automatic logic [17:0] model(input int w,
                                         input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic sub);
      longint m, ua, ub, sa, sv, r, u;
      logic c, o;
      m  = (longint'(1) << w) - 1;
      ua = longint'(a) & m;
      ub = longint'(b) & m;
      sa = a[w-1] ? ua - (m + 1) : ua;
      sv = b[w-1] ? ub - (m + 1) : ub;
      r  = sub ? sa - sv : sa + sv;
      o  = (r < -((m + 1) / 2)) || (r >= (m + 1) / 2);
      c  = sub ? (ua >= ub) : ((ua + ub) > m);
      u  = (sub ? ua - ub : ua + ub) & m;
      return {o, c, u[15:0]};
   endfunction

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            q[i].delete();
            hld[i] = 1'b0;
         end else begin
            if (hld[i]) begin
               chk(i ? "hold_v16" : "hold_v8", ov[i], 1);
               chk(i ? "hold_o16" : "hold_o8",
                   {14'd0, of[i], co[i], os[i]}, hv[i]);
            end
            chk(i ? "in_ready16" : "in_ready8",
                ir[i], !ov[i] || ordy[i]);
            if (iv[i] && ir[i]) begin
               q[i].push_back(model(i ? 16 : 8,
                                    ia[i], ib[i], sb[i]));
               npush[i]++;
            end
            if (ov[i] && ordy[i]) begin
               nout[i]++;
               if (q[i].size() == 0) begin
                  chk(i ? "unexpected16" : "unexpected8", 1, 0);
               end else begin
                  logic [17:0] e;
                  e = q[i].pop_front();
                  chk(i ? "sum16" : "sum8", os[i], e[15:0]);
                  chk(i ? "cout16" : "cout8", co[i], e[16]);
                  chk(i ? "ovf16" : "ovf8", of[i], e[17]);
               end
            end
            hld[i] = ov[i] && !ordy[i];
            hv[i]  = {of[i], co[i], os[i]};
         end
      end
   end

   task automatic dir(input string tag,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic sub, input logic [7:0] es,
                      input logic ec, input logic eo);
      int lat;
      @(posedge clk); #1;
      iv[0] = 1'b1; ia[0] = {8'h00, a};
      ib[0] = {8'h00, b}; sb[0] = sub;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      lat = 0;
      @(negedge clk);
      while (!ov[0] && lat < 10) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk({tag, "_lat"}, lat, 3);
      chk({tag, "_sum"}, os[0], {8'h00, es});
      chk({tag, "_cout"}, co[0], ec);
      chk({tag, "_ovf"}, of[0], eo);
   endtask

   task automatic rnd(input int i);
      int cyc;
      cyc = 0;
      while (npush[i] < 10000 && cyc < 60000) begin
         @(posedge clk); #1;
         iv[i]   = ($urandom_range(3) != 0);
         ia[i]   = 16'($urandom);
         ib[i]   = 16'($urandom);
         sb[i]   = 1'($urandom);
         ordy[i] = ($urandom_range(3) != 0);
         cyc++;
      end
      @(posedge clk); #1;
      iv[i]   = 1'b0;
      ordy[i] = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk(i ? "rnd_cnt16" : "rnd_cnt8", npush[i] >= 10000, 1);
      chk(i ? "rnd_drain16" : "rnd_drain8", q[i].size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int rec;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         iv[i] = 1'b0; ordy[i] = 1'b1; sb[i] = 1'b0;
         ia[i] = '0;   ib[i] = '0;
         npush[i] = 0; nout[i] = 0; hld[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_valid", ov[i], 0);
         chk("rst_sum", os[i], 0);
         chk("rst_cout", co[i], 0);
         chk("rst_ovf", of[i], 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rdy_after_rst8", ir[0], 1);
      chk("rdy_after_rst16", ir[1], 1);

      dir("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
      dir("sub1020", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
      dir("sub8001", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
      dir("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      dir("addffff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0);

      // six back-to-back transfers
      fork
         begin
            for (int n = 0; n < 6; n++) begin
               @(posedge clk); #1;
               iv[0] = 1'b1;
               ia[0] = 16'($urandom);
               ib[0] = 16'($urandom);
               sb[0] = 1'($urandom);
            end
            @(posedge clk); #1;
            iv[0] = 1'b0;
         end
         begin
            int t, run;
            t = 0; run = 0;
            do begin
               @(negedge clk);
               t++;
            end while (!ov[0] && t < 20);
            while (ov[0] && run < 10) begin
               run++;
               @(negedge clk);
            end
            chk("b2b_run", run, 6);
         end
      join
      repeat (4) @(posedge clk);

      // fill with consumer stalled, hold for three cycles
      rec = nout[0];
      @(posedge clk); #1;
      ordy[0] = 1'b0;
      for (int n = 0; n < 4; n++) begin
         iv[0] = 1'b1;
         ia[0] = 16'($urandom);
         ib[0] = 16'($urandom);
         sb[0] = 1'($urandom);
         @(posedge clk); #1;
      end
      for (int n = 0; n < 3; n++) begin
         ia[0] = 16'($urandom);
         ib[0] = 16'($urandom);
         @(negedge clk);
         chk("stall_in_ready", ir[0], 0);
         chk("stall_valid", ov[0], 1);
         @(posedge clk); #1;
      end
      ordy[0] = 1'b1;
      iv[0]   = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("stall_count", nout[0] - rec, 4);
      chk("stall_drain", q[0].size(), 0);

      // reset with three transactions in flight
      for (int n = 0; n < 3; n++) begin
         @(posedge clk); #1;
         iv[0] = 1'b1;
         ia[0] = 16'($urandom);
         ib[0] = 16'($urandom);
         sb[0] = 1'($urandom);
      end
      @(posedge clk); #1;
      iv[0] = 1'b0;
      rst   = 1'b1;
      rec   = nout[0];
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", ov[0], 0);
      chk("mid_rst_sum", os[0], 0);
      chk("mid_rst_cout", co[0], 0);
      chk("mid_rst_ovf", of[0], 0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("mid_rst_stale", nout[0], rec);

      npush[0] = 0;
      npush[1] = 0;
      fork
         rnd(0);
         rnd(1);
      join

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
